// File: rtl/wb_ccd_sequencer_if.sv
// Wishbone master bus bundle used by the CCD sequencer.
// The sequencer drives cyc/stb/we/addr/data; the slave returns ack.
interface wb_ccd_sequencer_if;
  logic        o_wb_cyc;
  logic        o_wb_stb;
  logic        o_wb_we;
  logic [31:0] o_wb_addr;
  logic [31:0] o_wb_data;
  logic        i_wb_ack;

  modport master (
    output o_wb_cyc,
    output o_wb_stb,
    output o_wb_we,
    output o_wb_addr,
    output o_wb_data,
    input  i_wb_ack
  );

  modport slave (
    input  o_wb_cyc,
    input  o_wb_stb,
    input  o_wb_we,
    input  o_wb_addr,
    input  o_wb_data,
    output i_wb_ack
  );
endinterface

// File: rtl/wb_ccd_sequencer.sv
// CCD signal-generator sequencer: on a start request it programs FREQUENCY,
// toggles CLOCK n times, enables the generator for a fixed number of cycles,
// disables it and finally writes RETURN, all as Wishbone single writes with
// one idle cycle between transactions and a per-transaction ack timeout.
module wb_ccd_sequencer #(
  parameter logic [31:0] BASE_ADDR = 32'h3000_0000,
  parameter int unsigned TIMEOUT   = 16
) (
  input  logic               i_wb_clk,
  input  logic               i_wb_rst_n,
  input  logic               i_start,
  input  logic [31:0]        i_freq_data,
  input  logic [7:0]         i_n_pulses,
  input  logic [23:0]        i_run_cycles,
  input  logic [31:0]        i_return_data,
  wb_ccd_sequencer_if.master wb,
  output logic               o_busy,
  output logic               o_done,
  output logic               o_error
);

  localparam logic [31:0] ADDR_EN   = BASE_ADDR + 32'h0000_0000;
  localparam logic [31:0] ADDR_FREQ = BASE_ADDR + 32'h0000_0004;
  localparam logic [31:0] ADDR_CLK  = BASE_ADDR + 32'h0000_0018;
  localparam logic [31:0] ADDR_RET  = BASE_ADDR + 32'h0000_001C;
  // Counter value at which the stalled transaction is abandoned.
  localparam logic [7:0]  TMO_LAST  = 8'(TIMEOUT - 1);

  typedef enum logic [3:0] {
    IDLE, WR_FREQ, CLK_HI, CLK_LO, WR_EN, RUN, WR_DIS, WR_RET, DONE
  } state_t;

  state_t      state_reg;
  logic        stb_reg;
  logic        gap_reg;     // current state's transaction waits for its idle gap cycle
  logic [31:0] addr_reg;
  logic [31:0] data_reg;
  logic [31:0] ret_reg;
  logic [7:0]  pulse_reg;   // CLOCK pairs still to be written
  logic [23:0] run_reg;     // RUN cycles still to be waited
  logic [7:0]  tmo_reg;     // stb cycles without ack in the current transaction
  logic        busy_reg;
  logic        done_reg;
  logic        error_reg;

  state_t      ack_next;
  logic [31:0] gap_addr;
  logic [31:0] gap_data;

  assign wb.o_wb_cyc  = stb_reg;
  assign wb.o_wb_stb  = stb_reg;
  assign wb.o_wb_we   = stb_reg;
  assign wb.o_wb_addr = addr_reg;
  assign wb.o_wb_data = data_reg;
  assign o_busy       = busy_reg;
  assign o_done       = done_reg;
  assign o_error      = error_reg;

  // State that follows an acknowledged transaction in the current state.
  always_comb begin
    ack_next = IDLE;
    case (state_reg)
      WR_FREQ: ack_next = (pulse_reg == 8'd0) ? WR_EN : CLK_HI;
      CLK_HI:  ack_next = CLK_LO;
      CLK_LO:  ack_next = (pulse_reg == 8'd1) ? WR_EN : CLK_HI;
      WR_EN:   ack_next = RUN;
      WR_DIS:  ack_next = WR_RET;
      WR_RET:  ack_next = DONE;
      default: ack_next = IDLE;
    endcase
  end

  // Address/data launched at the end of the gap cycle for the current state.
  always_comb begin
    gap_addr = ADDR_EN;
    gap_data = 32'd0;
    case (state_reg)
      CLK_HI: begin gap_addr = ADDR_CLK; gap_data = 32'd1;   end
      CLK_LO: begin gap_addr = ADDR_CLK; gap_data = 32'd0;   end
      WR_EN:  begin gap_addr = ADDR_EN;  gap_data = 32'd1;   end
      WR_DIS: begin gap_addr = ADDR_EN;  gap_data = 32'd0;   end
      WR_RET: begin gap_addr = ADDR_RET; gap_data = ret_reg; end
      default: begin gap_addr = ADDR_EN; gap_data = 32'd0;   end
    endcase
  end

  // Sequencer FSM with registered bus and status outputs.
  always_ff @(posedge i_wb_clk or negedge i_wb_rst_n) begin
    if (!i_wb_rst_n) begin
      state_reg <= IDLE;
      stb_reg   <= 1'b0;
      gap_reg   <= 1'b0;
      addr_reg  <= 32'd0;
      data_reg  <= 32'd0;
      ret_reg   <= 32'd0;
      pulse_reg <= 8'd0;
      run_reg   <= 24'd0;
      tmo_reg   <= 8'd0;
      busy_reg  <= 1'b0;
      done_reg  <= 1'b0;
      error_reg <= 1'b0;
    end else begin
      done_reg <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (i_start) begin
            // Latch the whole job; the FREQUENCY data rides in data_reg.
            ret_reg   <= i_return_data;
            pulse_reg <= i_n_pulses;
            run_reg   <= i_run_cycles;
            state_reg <= WR_FREQ;
            stb_reg   <= 1'b1;
            gap_reg   <= 1'b0;
            addr_reg  <= ADDR_FREQ;
            data_reg  <= i_freq_data;
            tmo_reg   <= 8'd0;
            busy_reg  <= 1'b1;
            error_reg <= 1'b0;
          end
        end
        RUN: begin
          // The first RUN cycle doubles as the gap after the WR_EN ack.
          if (run_reg == 24'd0) begin
            state_reg <= WR_DIS;
            stb_reg   <= 1'b1;
            addr_reg  <= ADDR_EN;
            data_reg  <= 32'd0;
            tmo_reg   <= 8'd0;
          end else begin
            run_reg <= run_reg - 24'd1;
          end
        end
        DONE: begin
          state_reg <= IDLE;
        end
        default: begin
          if (gap_reg) begin
            gap_reg  <= 1'b0;
            stb_reg  <= 1'b1;
            addr_reg <= gap_addr;
            data_reg <= gap_data;
            tmo_reg  <= 8'd0;
          end else if (stb_reg) begin
            if (wb.i_wb_ack) begin
              stb_reg   <= 1'b0;
              tmo_reg   <= 8'd0;
              state_reg <= ack_next;
              if (state_reg == CLK_LO) begin
                pulse_reg <= pulse_reg - 8'd1;
              end
              if (ack_next == DONE) begin
                busy_reg <= 1'b0;
                done_reg <= 1'b1;
              end else if (ack_next != RUN) begin
                gap_reg <= 1'b1;
              end
            end else if (tmo_reg == TMO_LAST) begin
              // Slave never answered: abandon the rest of the sequence.
              stb_reg   <= 1'b0;
              tmo_reg   <= 8'd0;
              error_reg <= 1'b1;
              busy_reg  <= 1'b0;
              done_reg  <= 1'b1;
              state_reg <= DONE;
            end else begin
              tmo_reg <= tmo_reg + 8'd1;
            end
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_wb_ccd_sequencer.sv
// Self-checking bench for wb_ccd_sequencer: a negedge monitor records every
// bus transaction and a slave model answers with a programmable ack delay;
// each scenario task compares the recorded writes against a list of writes
// derived from the job parameters.
module tb_wb_ccd_sequencer;
  localparam logic [31:0] BASE = 32'h3000_0000;
  localparam logic [31:0] A_EN   = BASE;
  localparam logic [31:0] A_FREQ = BASE + 32'h04;
  localparam logic [31:0] A_CLK  = BASE + 32'h18;
  localparam logic [31:0] A_RET  = BASE + 32'h1C;
  localparam int TMO = 16;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        i_start = 1'b0;
  logic [31:0] freq = 32'd0;
  logic [7:0]  npul = 8'd0;
  logic [23:0] runc = 24'd0;
  logic [31:0] retd = 32'd0;
  logic        busy, done, error;

  wb_ccd_sequencer_if wb();

  wb_ccd_sequencer #(.BASE_ADDR(BASE), .TIMEOUT(TMO)) dut (
    .i_wb_clk      (clk),
    .i_wb_rst_n    (rst_n),
    .i_start       (i_start),
    .i_freq_data   (freq),
    .i_n_pulses    (npul),
    .i_run_cycles  (runc),
    .i_return_data (retd),
    .wb            (wb.master),
    .o_busy        (busy),
    .o_done        (done),
    .o_error       (error)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;
  int cyc_no = 0;

  // Monitor records
  logic [31:0] obs_addr[$];
  logic [31:0] obs_data[$];
  int          obs_rise[$];
  int          obs_fall[$];
  int          obs_len[$];
  int          obs_done[$];
  int          stable_viol = 0;
  int          ctrl_viol = 0;
  logic        prev_stb = 1'b0;
  int          cur_len = 0;
  int          held = 0;
  int          ack_delay = 1;
  int          ack_delay_clk = 1;
  bit          spurious_en = 1'b0;

  // Expected write list
  logic [31:0] exp_addr[$];
  logic [31:0] exp_data[$];

  initial forever @(posedge clk) cyc_no++;

  // Bus monitor plus slave: sample at negedge, then drive ack for next edge.
  initial begin
    int dly;
    wb.i_wb_ack = 1'b0;
    forever begin
      @(negedge clk);
      if (wb.o_wb_cyc !== wb.o_wb_stb || (wb.o_wb_stb === 1'b1 && wb.o_wb_we !== 1'b1)) ctrl_viol++;
      if (wb.o_wb_stb === 1'b1 && busy !== 1'b1) ctrl_viol++;
      if (done === 1'b1 && (busy !== 1'b0 || wb.o_wb_cyc !== 1'b0)) ctrl_viol++;
      if (done === 1'b1) obs_done.push_back(cyc_no);
      if (wb.o_wb_stb === 1'b1 && !prev_stb) begin
        obs_rise.push_back(cyc_no);
        obs_addr.push_back(wb.o_wb_addr);
        obs_data.push_back(wb.o_wb_data);
        cur_len = 1;
      end else if (wb.o_wb_stb === 1'b1) begin
        if (obs_addr.size() > 0 &&
            (wb.o_wb_addr !== obs_addr[$] || wb.o_wb_data !== obs_data[$])) stable_viol++;
        cur_len++;
      end else if (prev_stb) begin
        obs_len.push_back(cur_len);
        obs_fall.push_back(cyc_no);
      end
      prev_stb = (wb.o_wb_stb === 1'b1);
      if (wb.o_wb_stb === 1'b1) begin
        dly = (wb.o_wb_addr == A_CLK) ? ack_delay_clk : ack_delay;
        wb.i_wb_ack = (held >= dly);
        held++;
      end else begin
        held = 0;
        wb.i_wb_ack = spurious_en ? 1'($urandom_range(0, 1)) : 1'b0;
      end
    end
  end

  // Reference model: the list of writes a job must produce.
  task automatic build_model(input logic [31:0] f, input logic [7:0] n, input logic [31:0] rt);
    exp_addr.delete();
    exp_data.delete();
    exp_addr.push_back(A_FREQ); exp_data.push_back(f);
    for (int p = 0; p < int'(n); p++) begin
      exp_addr.push_back(A_CLK); exp_data.push_back(32'd1);
      exp_addr.push_back(A_CLK); exp_data.push_back(32'd0);
    end
    exp_addr.push_back(A_EN);  exp_data.push_back(32'd1);
    exp_addr.push_back(A_EN);  exp_data.push_back(32'd0);
    exp_addr.push_back(A_RET); exp_data.push_back(rt);
  endtask

  task automatic clear_obs();
    obs_addr.delete(); obs_data.delete(); obs_rise.delete();
    obs_fall.delete(); obs_len.delete(); obs_done.delete();
    stable_viol = 0;
    ctrl_viol = 0;
  endtask

  // Pulse i_start for one cycle; sc is the cycle number in which it is sampled.
  task automatic do_start(input logic [31:0] f, input logic [7:0] n, input logic [23:0] r,
                          input logic [31:0] rt, output int sc);
    @(posedge clk); #1;
    clear_obs();
    i_start = 1'b1; freq = f; npul = n; runc = r; retd = rt;
    @(negedge clk); #2;
    sc = cyc_no;
    @(posedge clk); #1;
    i_start = 1'b0;
  endtask

  task automatic wait_done(input int budget, output bit ok);
    ok = 1'b0;
    for (int k = 0; k < budget; k++) begin
      @(negedge clk); #2;
      if (obs_done.size() > 0) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset();
    repeat (2) @(posedge clk);
    @(negedge clk); #2;
    vectors++; if (wb.o_wb_cyc !== 1'b0) begin miscompares++; $display("FAIL reset_cyc: got %b, expected 0", wb.o_wb_cyc); end
    vectors++; if (wb.o_wb_stb !== 1'b0) begin miscompares++; $display("FAIL reset_stb: got %b, expected 0", wb.o_wb_stb); end
    vectors++; if (wb.o_wb_we !== 1'b0) begin miscompares++; $display("FAIL reset_we: got %b, expected 0", wb.o_wb_we); end
    vectors++; if (wb.o_wb_addr !== 32'd0) begin miscompares++; $display("FAIL reset_addr: got %h, expected 0", wb.o_wb_addr); end
    vectors++; if (wb.o_wb_data !== 32'd0) begin miscompares++; $display("FAIL reset_data: got %h, expected 0", wb.o_wb_data); end
    vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL reset_busy: got %b, expected 0", busy); end
    vectors++; if (done !== 1'b0) begin miscompares++; $display("FAIL reset_done: got %b, expected 0", done); end
    vectors++; if (error !== 1'b0) begin miscompares++; $display("FAIL reset_error: got %b, expected 0", error); end
    @(posedge clk); #1;
    rst_n = 1'b1;
    clear_obs();
    spurious_en = 1'b1;
    freq = $urandom; npul = 8'($urandom); runc = 24'($urandom); retd = $urandom;
    repeat (12) @(posedge clk);
    @(negedge clk); #2;
    spurious_en = 1'b0;
    vectors++; if (obs_rise.size() !== 0) begin miscompares++; $display("FAIL idle_after_reset: got %0d writes, expected 0", obs_rise.size()); end
    vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL idle_busy: got %b, expected 0", busy); end
    $display("reset: outputs cleared, block stays idle");
  endtask

  // Full job with the given ack timing, checked write by write.
  task automatic test_sequence(input string tag, input logic [31:0] f, input logic [7:0] n,
                               input logic [23:0] r, input logic [31:0] rt,
                               input int dly, input int dlyc, input bit spur);
    int sc;
    bit ok;
    int m;
    int exp_gap;
    int exp_len;
    ack_delay = dly; ack_delay_clk = dlyc; spurious_en = spur;
    build_model(f, n, rt);
    do_start(f, n, r, rt, sc);
    wait_done(3000, ok);
    spurious_en = 1'b0;
    vectors++; if (!ok) begin miscompares++; $display("FAIL %s_done_timeout: got no o_done, expected one", tag); end
    vectors++; if (obs_addr.size() != exp_addr.size()) begin miscompares++; $display("FAIL %s_count: got %0d writes, expected %0d", tag, obs_addr.size(), exp_addr.size()); end
    m = (obs_addr.size() < exp_addr.size()) ? obs_addr.size() : exp_addr.size();
    if (obs_len.size() < m) m = obs_len.size();
    for (int i = 0; i < m; i++) begin
      vectors++; if (obs_addr[i] !== exp_addr[i]) begin miscompares++; $display("FAIL %s_addr[%0d]: got %h, expected %h", tag, i, obs_addr[i], exp_addr[i]); end
      vectors++; if (obs_data[i] !== exp_data[i]) begin miscompares++; $display("FAIL %s_data[%0d]: got %h, expected %h", tag, i, obs_data[i], exp_data[i]); end
      exp_len = ((exp_addr[i] == A_CLK) ? dlyc : dly) + 1;
      vectors++; if (obs_len[i] != exp_len) begin miscompares++; $display("FAIL %s_stb_len[%0d]: got %0d, expected %0d", tag, i, obs_len[i], exp_len); end
      if (i == 0) begin
        vectors++; if (obs_rise[0] - sc != 1) begin miscompares++; $display("FAIL %s_first_latency: got %0d, expected 1", tag, obs_rise[0] - sc); end
      end else begin
        exp_gap = (i == 2 * int'(n) + 2) ? int'(r) + 1 : 1;
        vectors++; if (obs_rise[i] - obs_fall[i-1] != exp_gap) begin miscompares++; $display("FAIL %s_gap[%0d]: got %0d, expected %0d", tag, i, obs_rise[i] - obs_fall[i-1], exp_gap); end
      end
    end
    if (ok && obs_fall.size() > 0) begin
      vectors++; if (obs_done[0] != obs_fall[$]) begin miscompares++; $display("FAIL %s_done_cycle: got %0d, expected %0d", tag, obs_done[0], obs_fall[$]); end
    end
    vectors++; if (error !== 1'b0) begin miscompares++; $display("FAIL %s_error: got %b, expected 0", tag, error); end
    vectors++; if (stable_viol != 0) begin miscompares++; $display("FAIL %s_stable: got %0d unstable cycles, expected 0", tag, stable_viol); end
    vectors++; if (ctrl_viol != 0) begin miscompares++; $display("FAIL %s_ctrl: got %0d control violations, expected 0", tag, ctrl_viol); end
    $display("%s: n=%0d run=%0d ack=%0d/%0d writes=%0d", tag, n, r, dly, dlyc, obs_addr.size());
  endtask

  task automatic test_timeout();
    int sc;
    bit ok;
    int nw;
    ack_delay = 100000; ack_delay_clk = 100000; spurious_en = 1'b0;
    do_start(32'hCAFE_0001, 8'd3, 24'd4, 32'h55, sc);
    wait_done(200, ok);
    vectors++; if (!ok) begin miscompares++; $display("FAIL tmo_done: got no o_done, expected one"); end
    vectors++; if (obs_len.size() != 1 || obs_len[0] != TMO) begin miscompares++; $display("FAIL tmo_stb_len: got %0d, expected %0d", (obs_len.size() > 0) ? obs_len[0] : -1, TMO); end
    vectors++; if (error !== 1'b1) begin miscompares++; $display("FAIL tmo_error: got %b, expected 1", error); end
    if (ok && obs_fall.size() > 0) begin
      vectors++; if (obs_done[0] != obs_fall[0]) begin miscompares++; $display("FAIL tmo_done_cycle: got %0d, expected %0d", obs_done[0], obs_fall[0]); end
    end
    nw = obs_rise.size();
    repeat (30) @(posedge clk);
    @(negedge clk); #2;
    vectors++; if (obs_rise.size() != nw) begin miscompares++; $display("FAIL tmo_no_more_writes: got %0d, expected %0d", obs_rise.size(), nw); end
    vectors++; if (error !== 1'b1) begin miscompares++; $display("FAIL tmo_sticky: got %b, expected 1", error); end
    ack_delay = 1; ack_delay_clk = 1;
    do_start(32'h1234_5678, 8'd1, 24'd2, 32'h9, sc);
    vectors++; if (error !== 1'b0) begin miscompares++; $display("FAIL tmo_clear_on_start: got %b, expected 0", error); end
    wait_done(500, ok);
    vectors++; if (obs_addr.size() != 6) begin miscompares++; $display("FAIL tmo_rerun_count: got %0d, expected 6", obs_addr.size()); end
    vectors++; if (error !== 1'b0) begin miscompares++; $display("FAIL tmo_rerun_error: got %b, expected 0", error); end
    $display("timeout: stalled write abandoned, error sticky then cleared");
  endtask

  task automatic test_ignore_start();
    int sc;
    bit ok;
    int m;
    logic [31:0] f0;
    logic [31:0] r0;
    f0 = $urandom; r0 = $urandom;
    ack_delay = 1; ack_delay_clk = 1; spurious_en = 1'b0;
    build_model(f0, 8'd2, r0);
    do_start(f0, 8'd2, 24'd12, r0, sc);
    ok = 1'b0;
    for (int k = 0; k < 200; k++) begin
      @(negedge clk); #2;
      if (obs_fall.size() == 6) begin ok = 1'b1; break; end
    end
    vectors++; if (!ok) begin miscompares++; $display("FAIL ign_reach_run: got %0d writes, expected 6", obs_fall.size()); end
    @(posedge clk); #1;
    i_start = 1'b1; freq = ~f0; npul = 8'd7; runc = 24'd1; retd = ~r0;
    @(posedge clk); #1;
    i_start = 1'b0; freq = $urandom; npul = 8'($urandom); retd = $urandom;
    wait_done(500, ok);
    vectors++; if (!ok) begin miscompares++; $display("FAIL ign_done: got no o_done, expected one"); end
    vectors++; if (obs_addr.size() != exp_addr.size()) begin miscompares++; $display("FAIL ign_count: got %0d, expected %0d", obs_addr.size(), exp_addr.size()); end
    m = (obs_addr.size() < exp_addr.size()) ? obs_addr.size() : exp_addr.size();
    for (int i = 0; i < m; i++) begin
      vectors++; if (obs_addr[i] !== exp_addr[i] || obs_data[i] !== exp_data[i]) begin miscompares++; $display("FAIL ign_write[%0d]: got %h/%h, expected %h/%h", i, obs_addr[i], obs_data[i], exp_addr[i], exp_data[i]); end
    end
    if (obs_rise.size() > 6 && obs_fall.size() > 5) begin
      vectors++; if (obs_rise[6] - obs_fall[5] != 13) begin miscompares++; $display("FAIL ign_run_gap: got %0d, expected 13", obs_rise[6] - obs_fall[5]); end
    end
    repeat (6) @(posedge clk);
    @(negedge clk); #2;
    vectors++; if (obs_rise.size() != exp_addr.size() || busy !== 1'b0) begin miscompares++; $display("FAIL ign_no_restart: got %0d writes busy=%b, expected %0d busy=0", obs_rise.size(), busy, exp_addr.size()); end
    $display("ignore_start: start during RUN dropped, latched values kept");
  endtask

  task automatic test_reset_mid();
    int sc;
    bit ok;
    int nw;
    ack_delay = 6; ack_delay_clk = 1; spurious_en = 1'b0;
    do_start(32'hABCD, 8'd1, 24'd3, 32'h77, sc);
    ok = 1'b0;
    for (int k = 0; k < 200; k++) begin
      @(negedge clk); #2;
      if (wb.o_wb_stb === 1'b1 && wb.o_wb_addr == A_EN && wb.o_wb_data == 32'd1) begin ok = 1'b1; break; end
    end
    vectors++; if (!ok) begin miscompares++; $display("FAIL rstmid_reach_en: got no WR_EN strobe, expected one"); end
    rst_n = 1'b0;
    #1;
    vectors++; if (wb.o_wb_cyc !== 1'b0 || wb.o_wb_stb !== 1'b0 || wb.o_wb_we !== 1'b0) begin miscompares++; $display("FAIL rstmid_ctrl: got cyc=%b stb=%b we=%b, expected 0", wb.o_wb_cyc, wb.o_wb_stb, wb.o_wb_we); end
    vectors++; if (wb.o_wb_addr !== 32'd0 || wb.o_wb_data !== 32'd0) begin miscompares++; $display("FAIL rstmid_bus: got %h/%h, expected 0/0", wb.o_wb_addr, wb.o_wb_data); end
    vectors++; if (busy !== 1'b0 || done !== 1'b0 || error !== 1'b0) begin miscompares++; $display("FAIL rstmid_status: got busy=%b done=%b error=%b, expected 0", busy, done, error); end
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    nw = obs_rise.size();
    repeat (10) @(posedge clk);
    @(negedge clk); #2;
    vectors++; if (obs_done.size() != 0) begin miscompares++; $display("FAIL rstmid_no_done: got %0d pulses, expected 0", obs_done.size()); end
    vectors++; if (obs_rise.size() != nw) begin miscompares++; $display("FAIL rstmid_stay_idle: got %0d writes, expected %0d", obs_rise.size(), nw); end
    $display("reset_mid: WR_EN abandoned without o_done");
    test_sequence("after_reset", 32'h0BAD_F00D, 8'd2, 24'd3, 32'h42, 1, 1, 1'b0);
  endtask

  initial begin
    test_reset();
    test_sequence("directed", 32'd0, 8'd2, 24'd5, 32'h1F, 1, 1, 1'b0);
    test_sequence("no_pulses", $urandom, 8'd0, 24'd0, $urandom, 1, 1, 1'b0);
    test_sequence("stall", $urandom, 8'd2, 24'd2, $urandom, 1, 3, 1'b1);
    for (int t = 0; t < 6; t++) begin
      test_sequence("random", $urandom, 8'($urandom_range(0, 4)), 24'($urandom_range(0, 10)),
                    $urandom, int'($urandom_range(0, 3)), int'($urandom_range(0, 3)), 1'b1);
    end
    test_timeout();
    test_ignore_start();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/wb_ccd_sequencer.md
WB_CCD_SEQUENCER -- requirements
Module: wb_ccd_sequencer

Interface
REQ-001 Parameter BASE_ADDR, 32'h3000_0000, base of the signal generator register map.
REQ-002 Parameter TIMEOUT, 16, maximum wait cycles for an ack per transaction (legal range 1..255).
REQ-003 Register offsets SHALL be fixed: ENABLE +0x00, FREQUENCY +0x04, CLOCK +0x18, RETURN +0x1C.
REQ-004 i_wb_clk  in  1  single clock; every flop on its rising edge.
REQ-005 i_wb_rst_n  in  1  asynchronous, active-low reset.
REQ-006 i_start  in  1  one-cycle request to run the sequence.
REQ-007 i_freq_data  in  32  data value written to FREQUENCY.
REQ-008 i_n_pulses  in  8  number of CLOCK 1/0 write pairs.
REQ-009 i_run_cycles  in  24  cycles to hold ENABLE=1 before disabling.
REQ-010 i_return_data  in  32  data value written to RETURN.
REQ-011 o_wb_cyc, o_wb_stb, o_wb_we  out  1 each  Wishbone master control.
REQ-012 o_wb_addr  out  32  transaction address.
REQ-013 o_wb_data  out  32  write data.
REQ-014 i_wb_ack  in  1  slave completion.
REQ-015 o_busy  out  1  high from the cycle after an accepted start until the cycle of o_done.
REQ-016 o_done  out  1  one-cycle pulse at the end of the sequence, including an aborted sequence.
REQ-017 o_error  out  1  sticky timeout flag, cleared by the next accepted start.

Function
REQ-018 On an accepted start, i_freq_data, i_n_pulses, i_run_cycles and i_return_data SHALL be latched; later input changes have no effect on the running sequence.
REQ-019 i_start while o_busy=1 SHALL be ignored.
REQ-020 FSM states: IDLE, WR_FREQ, CLK_HI, CLK_LO, WR_EN, RUN, WR_DIS, WR_RET, DONE.
REQ-021 Sequence: WR_FREQ(data=freq) -> n x (CLK_HI data=1, CLK_LO data=0) -> WR_EN(data=1) -> RUN -> WR_DIS(ENABLE, data=0) -> WR_RET(data=return) -> DONE -> IDLE.
REQ-022 All transactions SHALL be writes (o_wb_we=1 whenever o_wb_cyc=1); o_wb_cyc and o_wb_stb SHALL always be equal.
REQ-023 o_wb_addr and o_wb_data SHALL be registered and stable for the whole time o_wb_stb=1.
REQ-024 The first transaction's stb SHALL assert in the cycle after the start is accepted.
REQ-025 A transaction ends at the rising edge where i_wb_ack=1 is sampled with stb=1; stb SHALL be 0 in the next cycle.
REQ-026 Every two transactions SHALL be separated by exactly one idle cycle with cyc=stb=0.
REQ-027 i_wb_ack sampled while stb=0 SHALL be ignored.
REQ-028 When i_n_pulses=0, CLK_HI/CLK_LO SHALL be skipped and WR_EN follows WR_FREQ directly.
REQ-029 RUN SHALL hold cyc=0 for exactly i_run_cycles cycles, counted after the gap cycle following the WR_EN ack; when i_run_cycles=0, WR_DIS starts after the gap cycle.
REQ-030 Timeout: a counter SHALL increment each cycle with stb=1 and no ack; on reaching TIMEOUT, stb/cyc SHALL drop in the next cycle, o_error SHALL set, and the FSM SHALL go to DONE; the remaining transactions SHALL be skipped.
REQ-031 DONE SHALL last one cycle with o_done=1, o_busy=0, and cyc=0.
REQ-032 A new start is accepted in the cycle after DONE, that is, in IDLE.

Reset
REQ-033 Asserting i_wb_rst_n low at any time SHALL immediately force IDLE, o_wb_cyc=o_wb_stb=o_wb_we=0, o_wb_addr=o_wb_data=0, o_busy=0, o_done=0, o_error=0, and zero all counters.
REQ-034 Reset in the middle of a transaction SHALL abandon it with no o_done pulse.
REQ-035 After reset deassertion, the block SHALL stay in IDLE until an i_start is accepted.

Verification
REQ-036 Stimulus: start with freq=0, n=2, run=5, return=0x1F, ack one cycle after stb. Required response: writes in order (0x3000_0004,0), (0x18,1), (0x18,0), (0x18,1), (0x18,0), (0x00,1), then 5 quiet cycles, then (0x00,0), (0x1C,0x1F), then o_done=1 and o_error=0.
REQ-037 Stimulus: n=0, run=0. Required response: exactly 4 writes (FREQ, EN=1, EN=0, RET), each separated by one idle cycle.
REQ-038 Stimulus: ack never asserted. Required response: stb high for 16 cycles, then dropped; o_error=1 and o_done pulses; no further writes. A second start clears o_error.
REQ-039 Stimulus: ack stall of 3 cycles on the CLOCK write, plus a spurious ack while idle. Required response: addr and data stay stable for the whole stall; the spurious ack causes no state change.
REQ-040 Stimulus: i_start during RUN, then input changes mid-sequence. Required response: the start is ignored and the written values match the originally latched inputs.
REQ-041 Stimulus: i_wb_rst_n low during the WR_EN stb. Required response: all outputs go to 0 asynchronously, with no o_done; a subsequent start runs the full sequence.
